// File: rtl/shifter_pkg.sv
// Shared helpers for the I/Q adaptive shift/AGC block: width math, signed clamp
// and the shift-controller state encoding.
package shifter_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        TRACK  = 2'd1,
        ATTACK = 2'd2
    } agc_state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Clamp a signed value into the range of a width-bit two's complement number.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                      input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/iq_shift_agc_sat.sv
// Single-channel variable arithmetic right shift (floor) followed by saturation
// to the output width; purely combinational, instantiated once per channel.
module iq_sat_shift
    import shifter_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 12,
    parameter int SW        = 3
) (
    input  logic signed [IN_WIDTH-1:0]  x,
    input  logic        [SW-1:0]        shift,
    output logic signed [OUT_WIDTH-1:0] y,
    output logic                        clip
);

    logic signed [IN_WIDTH-1:0] shifted_s;
    logic signed [31:0]         wide_s;
    logic signed [31:0]         sat_s;

    // Shift, widen with sign extension, clamp and flag any clamping.
    always_comb begin
        shifted_s = x >>> shift;
        wide_s    = 32'(shifted_s);
        sat_s     = sat_signed(wide_s, OUT_WIDTH);
        y         = sat_s[OUT_WIDTH-1:0];
        clip      = (sat_s != wide_s);
    end

endmodule

// File: rtl/iq_shift_agc.sv
// Adaptive I/Q width reducer: windowed peak detector drives the shift amount
// (fast single-step attack, held release), with a manual override.
module iq_shift_agc
    import shifter_pkg::*;
#(
    parameter int  IN_WIDTH     = 16,
    parameter int  OUT_WIDTH    = 12,
    parameter int  WIN_LOG2     = 10,
    parameter int  HOLD_WINDOWS = 4,
    localparam int MAX_SHIFT    = IN_WIDTH - OUT_WIDTH,
    localparam int SW           = clog2(MAX_SHIFT + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_i,
    input  logic signed [IN_WIDTH-1:0]  in_q,
    input  logic                        auto_en,
    input  logic        [SW-1:0]        manual_shift,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out_i,
    output logic signed [OUT_WIDTH-1:0] out_q,
    output logic                        clip,
    output logic        [SW-1:0]        shift_cur
);

    localparam int                   RW          = clog2(HOLD_WINDOWS + 1);
    localparam logic [SW-1:0]        MAX_SHIFT_V = SW'(MAX_SHIFT);
    localparam logic [RW-1:0]        HOLD_V      = RW'(HOLD_WINDOWS);
    localparam logic [WIN_LOG2-1:0]  WIN_LAST    = '1;
    localparam logic [IN_WIDTH-2:0]  OUT_MAX     = (IN_WIDTH-1)'((1 << (OUT_WIDTH - 1)) - 1);

    agc_state_t              state_r, state_s;
    logic [SW-1:0]           shift_r, shift_s, s_req_s;
    logic [WIN_LOG2-1:0]     win_cnt_r, win_cnt_s;
    logic [IN_WIDTH-2:0]     peak_r, peak_s, mag_i_s, mag_q_s, mag_s, peak_eff_s;
    logic [RW-1:0]           rel_r, rel_s, rel_inc_s;
    logic                    att_used_r, att_used_s;
    logic                    clip_i_s, clip_q_s, clip_now_s, win_end_s;
    logic signed [OUT_WIDTH-1:0] y_i_s, y_q_s;

    // |v| with the most negative code clamped to the largest positive magnitude.
    function automatic logic [IN_WIDTH-2:0] abs_clamp(input logic signed [IN_WIDTH-1:0] v);
        logic signed [IN_WIDTH-1:0] n;
        n = -v;
        if (!v[IN_WIDTH-1]) begin
            return v[IN_WIDTH-2:0];
        end else if (n[IN_WIDTH-1]) begin
            return '1;
        end else begin
            return n[IN_WIDTH-2:0];
        end
    endfunction

    iq_sat_shift #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SW(SW)) u_sat_i (
        .x(in_i), .shift(shift_r), .y(y_i_s), .clip(clip_i_s)
    );

    iq_sat_shift #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SW(SW)) u_sat_q (
        .x(in_q), .shift(shift_r), .y(y_q_s), .clip(clip_q_s)
    );

    assign shift_cur = shift_r;

    // Peak tracking and the smallest shift that keeps the window peak in range.
    always_comb begin
        mag_i_s    = abs_clamp(in_i);
        mag_q_s    = abs_clamp(in_q);
        mag_s      = (mag_i_s > mag_q_s) ? mag_i_s : mag_q_s;
        peak_eff_s = (mag_s > peak_r) ? mag_s : peak_r;
        clip_now_s = clip_i_s | clip_q_s;
        win_end_s  = (win_cnt_r == WIN_LAST);
        rel_inc_s  = rel_r + RW'(1);
        s_req_s    = MAX_SHIFT_V;
        for (int s = MAX_SHIFT; s >= 0; s--) begin
            s_req_s = ((peak_eff_s >> s) <= OUT_MAX) ? SW'(s) : s_req_s;
        end
    end

    // Next-state logic for the shift controller and window bookkeeping.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        win_cnt_s  = win_cnt_r;
        peak_s     = peak_r;
        rel_s      = rel_r;
        att_used_s = att_used_r;
        if (!auto_en) begin
            state_s    = MANUAL;
            shift_s    = (manual_shift > MAX_SHIFT_V) ? MAX_SHIFT_V : manual_shift;
            win_cnt_s  = '0;
            peak_s     = '0;
            rel_s      = '0;
            att_used_s = 1'b0;
        end else begin
            case (state_r)
                MANUAL:  state_s = TRACK;
                TRACK:   state_s = TRACK;
                ATTACK:  state_s = TRACK;
                default: state_s = TRACK;
            endcase
            if (in_valid) begin
                win_cnt_s = win_cnt_r + WIN_LOG2'(1);
                if (win_end_s) begin
                    // Window decision overrides any fast attack on the same sample.
                    peak_s     = '0;
                    att_used_s = 1'b0;
                    if (s_req_s > shift_r) begin
                        shift_s = s_req_s;
                        rel_s   = '0;
                    end else if (s_req_s < shift_r) begin
                        if (rel_inc_s == HOLD_V) begin
                            shift_s = shift_r - SW'(1);
                            rel_s   = '0;
                        end else begin
                            rel_s = rel_inc_s;
                        end
                    end else begin
                        rel_s = '0;
                    end
                end else begin
                    peak_s = peak_eff_s;
                    if (clip_now_s && (state_r == TRACK) && !att_used_r &&
                        (shift_r < MAX_SHIFT_V)) begin
                        shift_s    = shift_r + SW'(1);
                        att_used_s = 1'b1;
                        state_s    = ATTACK;
                    end else begin
                        att_used_s = att_used_r;
                    end
                end
            end else begin
                win_cnt_s = win_cnt_r;
            end
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= TRACK;
            shift_r    <= MAX_SHIFT_V;
            win_cnt_r  <= '0;
            peak_r     <= '0;
            rel_r      <= '0;
            att_used_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            win_cnt_r  <= win_cnt_s;
            peak_r     <= peak_s;
            rel_r      <= rel_s;
            att_used_r <= att_used_s;
        end
    end

    // Output registers; sample values hold while in_valid is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            clip      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            clip      <= in_valid & clip_now_s;
            if (in_valid) begin
                out_i <= y_i_s;
                out_q <= y_q_s;
            end
        end
    end

endmodule

// File: tb/tb_iq_shift_agc.sv
// Directed bench for iq_shift_agc (IN 16 / OUT 12 / WIN 16 samples / HOLD 2)
// with a queue-based scoreboard drained by an independent output monitor.
module tb_iq_shift_agc;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_i = 16'sd0;
    logic signed [15:0] in_q = 16'sd0;
    logic               auto_en = 1'b1;
    logic [2:0]         manual_shift = 3'd0;
    logic               out_valid;
    logic signed [11:0] out_i;
    logic signed [11:0] out_q;
    logic               clip;
    logic [2:0]         shift_cur;

    typedef struct {
        logic [11:0] i;
        logic [11:0] q;
        logic        c;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        iv_prev = 1'b0;
    logic [11:0] last_i = 12'h000;
    logic [11:0] last_q = 12'h000;

    iq_shift_agc #(
        .IN_WIDTH(16), .OUT_WIDTH(12), .WIN_LOG2(4), .HOLD_WINDOWS(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
        .auto_en(auto_en), .manual_shift(manual_shift), .out_valid(out_valid),
        .out_i(out_i), .out_q(out_q), .clip(clip), .shift_cur(shift_cur)
    );

    always #5 clk = ~clk;

    // Reference: floor shift then clamp to 12 bits; returns {clip, value}.
    function automatic logic [12:0] model(input int x, input int s);
        int v;
        v = x >>> s;
        if (v > 2047) begin
            return {1'b1, 12'h7FF};
        end else if (v < -2048) begin
            return {1'b1, 12'h800};
        end else begin
            return {1'b0, v[11:0]};
        end
    endfunction

    task automatic send(input logic signed [15:0] i, input logic signed [15:0] q,
                        input logic [11:0] ei, input logic [11:0] eq, input logic ec);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_i     = i;
        in_q     = q;
        e.i = ei;
        e.q = eq;
        e.c = ec;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic check_shift(input logic [2:0] expv, input string name);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (shift_cur !== expv) begin
            errors++;
            $display("FAIL %s: shift_cur got %0d expected %0d", name, shift_cur, expv);
        end
    endtask

    // One 16-sample window: I=100 everywhere, Q=-peak at sample 3.
    task automatic win(input int peak, input int s);
        logic [12:0] mi;
        logic [12:0] mq;
        for (int k = 0; k < 16; k++) begin
            mi = model(100, s);
            mq = (k == 3) ? model(-peak, s) : model(0, s);
            send(16'(100), (k == 3) ? 16'(-peak) : 16'sd0, mi[11:0], mq[11:0], mi[12] | mq[12]);
        end
    endtask

    // Output monitor: checks valid alignment, scoreboard data, and hold during gaps.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            iv_prev = in_valid & reset_n;
            @(negedge clk);
            if (reset_n) begin
                checks++;
                if (out_valid !== iv_prev) begin
                    errors++;
                    $display("FAIL out_valid: got %b expected %b", out_valid, iv_prev);
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %h/%h with empty queue", out_i, out_q);
                    end else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (out_i !== e.i || out_q !== e.q || clip !== e.c) begin
                            errors++;
                            $display("FAIL sample: got i=%h q=%h clip=%b expected i=%h q=%h clip=%b",
                                     out_i, out_q, clip, e.i, e.q, e.c);
                        end
                        last_i = e.i;
                        last_q = e.q;
                    end
                end else begin
                    checks++;
                    if (clip !== 1'b0 || out_i !== last_i || out_q !== last_q) begin
                        errors++;
                        $display("FAIL hold: got i=%h q=%h clip=%b expected i=%h q=%h clip=0",
                                 out_i, out_q, clip, last_i, last_q);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset_n = 1'b0;
        #20 reset_n = 1'b1;
        idle(2);

        // 1. Reset mid-stream, then first sample at shift 4.
        send(16'sh0100, 16'sd0, 12'h010, 12'h000, 1'b0);
        send(16'sh0100, 16'sd0, 12'h010, 12'h000, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_i !== 12'h000 || out_q !== 12'h000 ||
            clip !== 1'b0 || shift_cur !== 3'd4) begin
            errors++;
            $display("FAIL reset: got v=%b i=%h q=%h clip=%b shift=%0d expected 0/000/000/0/4",
                     out_valid, out_i, out_q, clip, shift_cur);
        end
        exp_q.delete();
        last_i = 12'h000;
        last_q = 12'h000;
        @(negedge clk);
        #2 reset_n = 1'b1;
        send(16'sh7FF0, 16'sd0, 12'h7FF, 12'h000, 1'b0);

        // 2. Manual override, saturation both ways, clamp of manual_shift.
        auto_en      = 1'b0;
        manual_shift = 3'd0;
        check_shift(3'd0, "manual0");
        send(16'sh0800, 16'sd0, 12'h7FF, 12'h000, 1'b1);
        send(16'sd0, -16'sd3000, 12'h000, 12'h800, 1'b1);
        send(16'sh0123, -16'sd5, 12'h123, 12'hFFB, 1'b0);
        manual_shift = 3'd7;
        check_shift(3'd4, "manual_clamp");
        send(16'sh0800, -16'sd17, 12'h080, 12'hFFE, 1'b0);

        // 3. Fast attack, single attack per window, window-end raise.
        manual_shift = 3'd0;
        check_shift(3'd0, "manual_back0");
        auto_en = 1'b1;
        idle(1);
        for (int k = 0; k < 5; k++) send(16'sd1000, 16'sd0, 12'h3E8, 12'h000, 1'b0);
        send(16'sd5000, 16'sd0, 12'h7FF, 12'h000, 1'b1);
        check_shift(3'd1, "fast_attack");
        send(16'sd5000, 16'sd0, 12'h7FF, 12'h000, 1'b1);
        check_shift(3'd1, "one_attack_per_window");
        for (int k = 7; k < 16; k++) send(16'sd1000, 16'sd0, 12'h1F4, 12'h000, 1'b0);
        check_shift(3'd2, "window_attack");

        // 4. Held release, interrupted by an in-range window.
        win(300, 2);
        check_shift(3'd2, "release_hold1");
        win(300, 2);
        check_shift(3'd1, "release_step");
        win(300, 1);
        check_shift(3'd1, "release_hold2");
        win(3000, 1);
        check_shift(3'd1, "equal_window");
        win(300, 1);
        check_shift(3'd1, "release_count_restarted");
        win(300, 1);
        check_shift(3'd0, "release_to_zero");

        // 5. Gapped input: window closes on the 16th valid sample, clip at window end.
        for (int k = 0; k < 15; k++) begin
            send(16'sd200, 16'(-10 * k), 12'h0C8, 12'(-10 * k), 1'b0);
            idle(1);
        end
        check_shift(3'd0, "no_early_window_end");
        send(16'sd5000, 16'sd0, 12'h7FF, 12'h000, 1'b1);
        idle(1);
        check_shift(3'd2, "clip_at_window_end");

        // 6. Most-negative input at window end.
        for (int k = 0; k < 15; k++) send(16'sd100, 16'sd0, 12'h019, 12'h000, 1'b0);
        send(-16'sd32768, 16'sd0, 12'h800, 12'h000, 1'b1);
        check_shift(3'd4, "abs_clamp_window_end");
        send(-16'sd32768, 16'sh7FFF, 12'h800, 12'h7FF, 1'b0);
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending outputs expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
